// File: rtl/kw_fifo_stream_reader_if.sv
// ---------------------------------------------------------------------------
// kw_fifo_stream_reader_if
//
// Purpose:
//   Valid/ready stream bundle that carries FIFO head words out of the
//   kw_fifo_stream_reader drain engine to a downstream consumer.
//
// Signals:
//   m_valid  producer -> consumer   stream data valid
//   m_ready  consumer -> producer   consumer can take a word this cycle
//   m_data   producer -> consumer   stream data word (DATA_WIDTH bits)
//
// Modports:
//   master   the drain engine side (drives m_valid/m_data, reads m_ready)
//   slave    the consumer side (reads m_valid/m_data, drives m_ready)
// ---------------------------------------------------------------------------
interface kw_fifo_stream_reader_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;

    modport master (
        output m_valid,
        output m_data,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        output m_ready
    );
endinterface

// File: rtl/kw_fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// kw_fifo_stream_reader
//
// Purpose:
//   Pop-side drain engine for KW_fifo. It issues pop requests to the FIFO,
//   captures the returned words into a 2-entry skid buffer and presents the
//   head of that buffer as a valid/ready stream. The skid buffer lets a FIFO
//   with a registered read port still deliver one word per cycle. A sticky
//   status bit records any FIFO error until it is cleared.
//
// Parameters:
//   DATA_WIDTH  width of FIFO data and stream data
//   RD_LAT      FIFO read latency: 0 = data valid in the pop cycle (FWFT),
//               1 = data valid the cycle after the pop
//
// Ports:
//   clock       in   single clock, rising edge
//   reset_n     in   asynchronous, active-low reset
//   pop_req     out  pop request to the FIFO
//   fifo_data   in   FIFO read data
//   fifo_empty  in   FIFO empty flag
//   fifo_error  in   FIFO error flag, active high
//   stream      if   master side of the output stream (m_valid/m_ready/m_data)
//   err_sticky  out  set when fifo_error is seen, held until err_clr
//   err_clr     in   synchronous clear of err_sticky (wins over fifo_error)
// ---------------------------------------------------------------------------
module kw_fifo_stream_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int RD_LAT     = 1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    output logic                   pop_req,
    input  logic [DATA_WIDTH-1:0]  fifo_data,
    input  logic                   fifo_empty,
    input  logic                   fifo_error,
    kw_fifo_stream_reader_if.master stream,
    output logic                   err_sticky,
    input  logic                   err_clr
);

    // Buffer occupancy: number of words held in the skid buffer.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_t;

    occ_t                  state;
    occ_t                  state_next;
    logic                  inflight;
    logic                  wr;
    logic                  deq;
    logic                  wr_slot0;
    logic [2:0]            committed;
    logic [DATA_WIDTH-1:0] slot1;
    logic [DATA_WIDTH-1:0] slot0_next;
    logic [DATA_WIDTH-1:0] slot1_next;

    assign deq = stream.m_valid & stream.m_ready;

    // Words that will still be owned after this cycle: held plus pending
    // minus the one leaving. A pop is only allowed if that leaves room, so
    // the buffer can never be asked to hold a third word.
    assign committed = 3'(state) + 3'(inflight) - 3'(deq);
    assign pop_req   = reset_n & ~fifo_empty & (committed < 3'd2);

    // With a registered FIFO read, the popped word arrives one cycle later,
    // so the pop is remembered in inflight and the write happens then.
    if (RD_LAT == 0) begin : g_fwft
        assign inflight = 1'b0;
        assign wr       = pop_req;
    end else begin : g_registered
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                inflight <= 1'b0;
            end else begin
                inflight <= pop_req;
            end
        end
        assign wr = inflight;
    end

    // Occupancy state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= OCC_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Occupancy next-state: +1 on write, -1 on dequeue.
    always_comb begin
        state_next = state;
        unique case (state)
            OCC_EMPTY: begin
                if (wr) begin
                    state_next = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (wr && !deq) begin
                    state_next = OCC_TWO;
                end else if (!wr && deq) begin
                    state_next = OCC_EMPTY;
                end
            end
            OCC_TWO: begin
                if (deq && !wr) begin
                    state_next = OCC_ONE;
                end
            end
            default: state_next = OCC_EMPTY;
        endcase
    end

    // Skid buffer datapath. slot0 is the registered m_data itself. A new
    // word lands in slot0 when the buffer is (or is becoming) empty,
    // otherwise behind the head in slot1; a dequeue from a full buffer
    // shifts slot1 forward.
    always_comb begin
        slot0_next = stream.m_data;
        slot1_next = slot1;
        wr_slot0   = (state == OCC_EMPTY) || ((state == OCC_ONE) && deq);
        if (deq && (state == OCC_TWO)) begin
            slot0_next = slot1;
        end
        if (wr) begin
            if (wr_slot0) begin
                slot0_next = fifo_data;
            end else begin
                slot1_next = fifo_data;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stream.m_valid <= 1'b0;
            stream.m_data  <= '0;
            slot1          <= '0;
        end else begin
            stream.m_valid <= (state_next != OCC_EMPTY);
            stream.m_data  <= slot0_next;
            slot1          <= slot1_next;
        end
    end

    // Sticky error flag; a clear in the same cycle as an error wins.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_sticky <= 1'b0;
        end else begin
            err_sticky <= (err_sticky | fifo_error) & ~err_clr;
        end
    end

endmodule

// File: tb/tb_kw_fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_kw_fifo_stream_reader
//
// Purpose:
//   Self-checking bench for kw_fifo_stream_reader. Two DUT lanes run side by
//   side (RD_LAT=0 and RD_LAT=1), each fed by its own FIFO model that pops
//   from a shared push log. The reference is the push log itself: every word
//   leaving a lane must be the next pushed word, words held plus pending must
//   never exceed two, and a stalled head must stay put.
// ---------------------------------------------------------------------------
module tb_kw_fifo_stream_reader;

    localparam int DW = 16;

    logic          clock      = 1'b0;
    logic          reset_n    = 1'b0;
    logic          m_ready    = 1'b0;
    logic          fifo_error = 1'b0;
    logic          err_clr    = 1'b0;

    logic [DW-1:0] push_mem [0:2047];
    int            push_count = 0;
    int            flush_to   = 0;

    logic [1:0]    pop_v;
    logic [1:0]    valid_v;
    logic [1:0]    empty_v;
    logic [1:0]    err_v;
    logic [DW-1:0] data_v [2];

    int            checks   = 0;
    int            failures = 0;
    int            exp_idx [2];
    int            pops [2];
    int            deqs [2];
    logic          prev_hold [2];
    logic [DW-1:0] prev_data [2];

    always #5 clock = ~clock;

    for (genvar g = 0; g < 2; g++) begin : lane
        kw_fifo_stream_reader_if #(.DATA_WIDTH(DW)) sif ();
        logic [DW-1:0] fifo_data;
        logic          fifo_empty;
        int            rd_ptr   = 0;
        logic [DW-1:0] data_reg = '0;

        kw_fifo_stream_reader #(.DATA_WIDTH(DW), .RD_LAT(g)) dut (
            .clock      (clock),
            .reset_n    (reset_n),
            .pop_req    (pop_v[g]),
            .fifo_data  (fifo_data),
            .fifo_empty (fifo_empty),
            .fifo_error (fifo_error),
            .stream     (sif),
            .err_sticky (err_v[g]),
            .err_clr    (err_clr)
        );

        // FIFO model: contents are push_mem[rd_ptr .. push_count-1].
        always @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                rd_ptr   <= flush_to;
                data_reg <= '0;
            end else if (pop_v[g]) begin
                data_reg <= push_mem[rd_ptr[10:0]];
                rd_ptr   <= rd_ptr + 1;
            end
        end

        assign fifo_empty = (rd_ptr >= push_count);
        if (g == 0) begin : g_fwft
            assign fifo_data = push_mem[rd_ptr[10:0]];
        end else begin : g_reg
            assign fifo_data = data_reg;
        end

        assign sif.m_ready = m_ready;
        assign valid_v[g]  = sif.m_valid;
        assign data_v[g]   = sif.m_data;
        assign empty_v[g]  = fifo_empty;
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        push_mem[push_count[10:0]] = w;
        push_count++;
    endtask

    // One clock cycle: per-cycle model checks at the falling edge, then
    // return 1 time unit after the rising edge for the next stimulus.
    task automatic step();
        @(negedge clock);
        if (reset_n) begin
            for (int l = 0; l < 2; l++) begin
                check_output($sformatf("lane%0d pop_while_empty", l),
                             32'(pop_v[l] & empty_v[l]), 32'd0);
                if (prev_hold[l]) begin
                    check_output($sformatf("lane%0d hold_valid", l), 32'(valid_v[l]), 32'd1);
                    check_output($sformatf("lane%0d hold_data", l), 32'(data_v[l]),
                                 32'(prev_data[l]));
                end
                if (pop_v[l]) pops[l]++;
                if (valid_v[l] && m_ready) begin
                    check_output($sformatf("lane%0d order[%0d]", l, exp_idx[l]),
                                 32'(data_v[l]), 32'(push_mem[exp_idx[l][10:0]]));
                    exp_idx[l]++;
                    deqs[l]++;
                end
                check_output($sformatf("lane%0d occ_bound", l),
                             32'((pops[l] - deqs[l]) <= 2), 32'd1);
                prev_hold[l] = valid_v[l] & ~m_ready;
                prev_data[l] = data_v[l];
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic enter_reset();
        flush_to = push_count;
        reset_n  = 1'b0;
        for (int l = 0; l < 2; l++) begin
            exp_idx[l]   = push_count;
            pops[l]      = 0;
            deqs[l]      = 0;
            prev_hold[l] = 1'b0;
        end
    endtask

    task automatic drain(input int budget, input bit rand_ready);
        int n = 0;
        while ((exp_idx[0] < push_count || exp_idx[1] < push_count) && n < budget) begin
            if (rand_ready) m_ready = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        check_output("drain_done",
                     32'((exp_idx[0] == push_count) && (exp_idx[1] == push_count)), 32'd1);
    endtask

    task automatic apply_stimulus();
        int p0 [2];
        int pushed;
        int n;

        for (int i = 0; i < 2048; i++) push_mem[i] = '0;
        enter_reset();

        // Reset held with a non-empty FIFO.
        m_ready = 1'b1;
        push_word(16'h1111);
        push_word(16'h2222);
        push_word(16'h3333);
        push_word(16'h4444);
        repeat (3) step();
        for (int l = 0; l < 2; l++) begin
            check_output($sformatf("lane%0d reset pop_req", l), 32'(pop_v[l]), 32'd0);
            check_output($sformatf("lane%0d reset m_valid", l), 32'(valid_v[l]), 32'd0);
            check_output($sformatf("lane%0d reset m_data", l), 32'(data_v[l]), 32'd0);
            check_output($sformatf("lane%0d reset err", l), 32'(err_v[l]), 32'd0);
        end
        reset_n = 1'b1;
        #1;
        check_output("release pop_req", 32'(pop_v), 32'h3);
        step();
        check_output("lane0 first valid", 32'(valid_v[0]), 32'd1);
        check_output("lane0 first data", 32'(data_v[0]), 32'h1111);
        check_output("lane1 first valid early", 32'(valid_v[1]), 32'd0);
        step();
        check_output("lane1 first valid", 32'(valid_v[1]), 32'd1);
        check_output("lane1 first data", 32'(data_v[1]), 32'h1111);
        drain(50, 1'b0);

        // Latency and full throughput with 0x0001..0x0008.
        m_ready = 1'b1;
        for (int k = 1; k <= 8; k++) push_word(16'(k));
        step();
        check_output("lane0 latency valid", 32'(valid_v[0]), 32'd1);
        check_output("lane0 latency data", 32'(data_v[0]), 32'h0001);
        check_output("lane1 latency early", 32'(valid_v[1]), 32'd0);
        step();
        for (int k = 1; k <= 8; k++) begin
            check_output($sformatf("lane1 burst valid %0d", k), 32'(valid_v[1]), 32'd1);
            check_output($sformatf("lane1 burst data %0d", k), 32'(data_v[1]), 32'(k));
            step();
        end
        drain(20, 1'b0);

        // Stalled consumer with five words waiting.
        m_ready = 1'b0;
        for (int k = 1; k <= 5; k++) push_word(16'(k));
        p0[0] = pops[0];
        p0[1] = pops[1];
        repeat (6) step();
        for (int l = 0; l < 2; l++) begin
            check_output($sformatf("lane%0d stall pops", l), 32'(pops[l] - p0[l]), 32'd2);
            check_output($sformatf("lane%0d stall pop_req", l), 32'(pop_v[l]), 32'd0);
            check_output($sformatf("lane%0d stall valid", l), 32'(valid_v[l]), 32'd1);
            check_output($sformatf("lane%0d stall data", l), 32'(data_v[l]), 32'h0001);
        end
        m_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            for (int l = 0; l < 2; l++) begin
                check_output($sformatf("lane%0d release valid %0d", l, k), 32'(valid_v[l]), 32'd1);
                check_output($sformatf("lane%0d release data %0d", l, k), 32'(data_v[l]), 32'(k));
            end
            step();
        end
        drain(20, 1'b0);

        // Sticky error flag.
        fifo_error = 1'b1;
        step();
        fifo_error = 1'b0;
        check_output("err set", 32'(err_v), 32'h3);
        step();
        check_output("err held", 32'(err_v), 32'h3);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check_output("err cleared", 32'(err_v), 32'h0);
        fifo_error = 1'b1;
        step();
        fifo_error = 1'b0;
        check_output("err set again", 32'(err_v), 32'h3);
        fifo_error = 1'b1;
        err_clr    = 1'b1;
        step();
        fifo_error = 1'b0;
        err_clr    = 1'b0;
        check_output("err clear wins", 32'(err_v), 32'h0);

        // Random traffic: 1000 words with a randomly toggling consumer.
        pushed = 0;
        n      = 0;
        while (pushed < 1000 && n < 20000) begin
            m_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) != 0) begin
                push_word(16'($urandom));
                pushed++;
            end
            step();
            n++;
        end
        check_output("random pushes", 32'(pushed), 32'd1000);
        drain(4000, 1'b1);

        // Reset mid-operation with a full buffer.
        m_ready = 1'b0;
        for (int k = 1; k <= 5; k++) push_word(16'h0500 + 16'(k));
        repeat (4) step();
        check_output("pre-reset lane1 valid", 32'(valid_v[1]), 32'd1);
        enter_reset();
        #1;
        check_output("async reset m_valid", 32'(valid_v), 32'h0);
        check_output("async reset pop_req", 32'(pop_v), 32'h0);
        repeat (2) step();
        reset_n = 1'b1;
        m_ready = 1'b1;
        push_word(16'h00A0);
        push_word(16'h00A1);
        push_word(16'h00A2);
        step();
        step();
        check_output("post-reset lane1 valid", 32'(valid_v[1]), 32'd1);
        check_output("post-reset lane1 data", 32'(data_v[1]), 32'h00A0);
        drain(30, 1'b0);
    endtask

    initial begin
        apply_stimulus();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
